// File: rtl/ramb16_ctl_pkg.sv
// Shared sizing constants and controller state encoding for the 4Kx4 RAM port arbiter.
// No logic; imported by the arbiter top.
// No flow control of its own.
package ramb16_ctl_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4096;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/ramb16_rr_arb2.sv
// Two-way arbiter, round-robin or fixed priority (req[0] wins).
// Grant is combinational from req and the priority pointer; pointer moves one cycle later.
// Losing requester simply stays asserted until granted.
module ramb16_rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // High when req[1] won most recently, giving req[0] the next contention.
    logic last_r1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r1_q <= 1'b1;
        end else if (advance) begin
            last_r1_q <= gnt[1];
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            if (RR_EN && !last_r1_q) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end
    end

endmodule

// File: rtl/ramb16_s4_arb.sv
// Shares one 4Kx4 RAM port between two requesters, with an optional full-array clear sweep.
// Grant and RAM drive are same-cycle; read data returns with RVALID one cycle after the grant.
// Requesters hold REQ until granted; no grants during CLR_START or the 4096-cycle sweep.
module ramb16_s4_arb
    import ramb16_ctl_pkg::*;
#(
    parameter bit                RR_EN      = 1'b1,
    parameter logic [DATA_W-1:0] CLR_VAL    = 4'h0,
    parameter bit                CLR_ON_RST = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              R0_REQ,
    input  logic              R1_REQ,
    input  logic              R0_WE,
    input  logic              R1_WE,
    input  logic [ADDR_W-1:0] R0_ADDR,
    input  logic [ADDR_W-1:0] R1_ADDR,
    input  logic [DATA_W-1:0] R0_DI,
    input  logic [DATA_W-1:0] R1_DI,
    output logic              R0_GNT,
    output logic              R1_GNT,
    output logic              R0_RVALID,
    output logic              R1_RVALID,
    output logic [DATA_W-1:0] R0_DO,
    output logic [DATA_W-1:0] R1_DO,
    input  logic              CLR_START,
    output logic              CLR_BUSY,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DI,
    input  logic [DATA_W-1:0] RAM_DO
);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                serve_ok;
    logic [1:0]          req_vld;
    logic [1:0]          gnt;
    logic [1:0]          rvalid_q;
    logic [DATA_W-1:0]   do0_q;
    logic [DATA_W-1:0]   do1_q;

    // Reset is folded in combinationally so grants and RAM drive drop the instant RST_N falls.
    assign serve_ok = RST_N && (state_q == SERVE) && !CLR_START;
    assign req_vld  = {R1_REQ, R0_REQ} & {2{serve_ok}};

    ramb16_rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk     (CLK),
        .rst_n   (RST_N),
        .req     (req_vld),
        .advance (|gnt),
        .gnt     (gnt)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= CLR_ON_RST ? CLEAR : SERVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SERVE:   if (CLR_START) state_d = CLEAR;
            CLEAR:   if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = SERVE;
            default: state_d = SERVE;
        endcase
    end

    always_comb begin
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = '0;
        RAM_DI   = '0;
        if (RST_N) begin
            case (state_q)
                CLEAR: begin
                    RAM_EN   = 1'b1;
                    RAM_WE   = 1'b1;
                    RAM_ADDR = clr_cnt_q;
                    RAM_DI   = CLR_VAL;
                end
                default: begin
                    if (gnt[0]) begin
                        RAM_EN   = 1'b1;
                        RAM_WE   = R0_WE;
                        RAM_ADDR = R0_ADDR;
                        RAM_DI   = R0_DI;
                    end else if (gnt[1]) begin
                        RAM_EN   = 1'b1;
                        RAM_WE   = R1_WE;
                        RAM_ADDR = R1_ADDR;
                        RAM_DI   = R1_DI;
                    end
                end
            endcase
        end
    end

    assign CLR_BUSY = RST_N && (state_q == CLEAR);
    assign R0_GNT   = gnt[0];
    assign R1_GNT   = gnt[1];

    // Counter only moves while sweeping and wraps to 0 on the last address.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clr_cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rvalid_q <= '0;
            do0_q    <= '0;
            do1_q    <= '0;
        end else begin
            rvalid_q <= {gnt[1] & ~R1_WE, gnt[0] & ~R0_WE};
            if (rvalid_q[0]) do0_q <= RAM_DO;
            if (rvalid_q[1]) do1_q <= RAM_DO;
        end
    end

    // RAM_DO is registered in the RAM, so it passes straight through in the RVALID cycle.
    assign R0_RVALID = rvalid_q[0];
    assign R1_RVALID = rvalid_q[1];
    assign R0_DO     = rvalid_q[0] ? RAM_DO : do0_q;
    assign R1_DO     = rvalid_q[1] ? RAM_DO : do1_q;

endmodule

// File: tb/tb_ramb16_s4_arb.sv
// Directed bench: round-robin main instance with a RAM model, plus fixed-priority and clear-on-reset instances.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Requesters hold REQ until granted.
module tb_ramb16_s4_arb;

    logic        clk = 1'b0;
    logic        rst_n, rst_n_c;
    logic        r0_req, r1_req, r0_we, r1_we, clr_start;
    logic [11:0] r0_addr, r1_addr;
    logic [3:0]  r0_di, r1_di;

    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, clr_busy, ram_en, ram_we;
    logic [3:0]  r0_do, r1_do, ram_di, ram_do;
    logic [11:0] ram_addr;

    logic        f_r0_gnt, f_r1_gnt, f_r0_rvalid, f_r1_rvalid, f_clr_busy, f_ram_en, f_ram_we;
    logic [3:0]  f_r0_do, f_r1_do, f_ram_di;
    logic [11:0] f_ram_addr;

    logic        c_r0_gnt, c_r1_gnt, c_r0_rvalid, c_r1_rvalid, c_clr_busy, c_ram_en, c_ram_we;
    logic [3:0]  c_r0_do, c_r1_do, c_ram_di;
    logic [11:0] c_ram_addr;

    logic [3:0]  mem [4096];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            else        ram_do <= mem[ram_addr];
        end
    end

    ramb16_s4_arb #(.RR_EN(1'b1), .CLR_VAL(4'h5), .CLR_ON_RST(1'b0)) dut (
        .CLK(clk), .RST_N(rst_n),
        .R0_REQ(r0_req), .R1_REQ(r1_req), .R0_WE(r0_we), .R1_WE(r1_we),
        .R0_ADDR(r0_addr), .R1_ADDR(r1_addr), .R0_DI(r0_di), .R1_DI(r1_di),
        .R0_GNT(r0_gnt), .R1_GNT(r1_gnt), .R0_RVALID(r0_rvalid), .R1_RVALID(r1_rvalid),
        .R0_DO(r0_do), .R1_DO(r1_do), .CLR_START(clr_start), .CLR_BUSY(clr_busy),
        .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_ADDR(ram_addr), .RAM_DI(ram_di), .RAM_DO(ram_do)
    );

    ramb16_s4_arb #(.RR_EN(1'b0), .CLR_VAL(4'h0), .CLR_ON_RST(1'b0)) dut_fp (
        .CLK(clk), .RST_N(rst_n),
        .R0_REQ(r0_req), .R1_REQ(r1_req), .R0_WE(r0_we), .R1_WE(r1_we),
        .R0_ADDR(r0_addr), .R1_ADDR(r1_addr), .R0_DI(r0_di), .R1_DI(r1_di),
        .R0_GNT(f_r0_gnt), .R1_GNT(f_r1_gnt), .R0_RVALID(f_r0_rvalid), .R1_RVALID(f_r1_rvalid),
        .R0_DO(f_r0_do), .R1_DO(f_r1_do), .CLR_START(1'b0), .CLR_BUSY(f_clr_busy),
        .RAM_EN(f_ram_en), .RAM_WE(f_ram_we), .RAM_ADDR(f_ram_addr), .RAM_DI(f_ram_di), .RAM_DO(4'h0)
    );

    ramb16_s4_arb #(.RR_EN(1'b1), .CLR_VAL(4'h0), .CLR_ON_RST(1'b1)) dut_cr (
        .CLK(clk), .RST_N(rst_n_c),
        .R0_REQ(r0_req), .R1_REQ(r1_req), .R0_WE(r0_we), .R1_WE(r1_we),
        .R0_ADDR(r0_addr), .R1_ADDR(r1_addr), .R0_DI(r0_di), .R1_DI(r1_di),
        .R0_GNT(c_r0_gnt), .R1_GNT(c_r1_gnt), .R0_RVALID(c_r0_rvalid), .R1_RVALID(c_r1_rvalid),
        .R0_DO(c_r0_do), .R1_DO(c_r1_do), .CLR_START(1'b0), .CLR_BUSY(c_clr_busy),
        .RAM_EN(c_ram_en), .RAM_WE(c_ram_we), .RAM_ADDR(c_ram_addr), .RAM_DI(c_ram_di), .RAM_DO(4'h0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [11:0] a, input logic [3:0] exp);
        step();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = a;
        @(negedge clk);
        check("rd_gnt", r0_gnt, 1);
        step();
        r0_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid", r0_rvalid, 1);
        check("rd_data", r0_do, exp);
    endtask

    initial begin
        int f0, f1, busy_n, gnt_n, addr_ok;
        rst_n = 1'b0; rst_n_c = 1'b0; clr_start = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b0; r1_we = 1'b0;
        r0_addr = '0; r1_addr = '0; r0_di = '0; r1_di = '0;
        f0 = 0; f1 = 0;

        // Reset state, with both requests already high
        repeat (2) @(negedge clk);
        check("rst_r0_gnt", r0_gnt, 0);
        check("rst_r1_gnt", r1_gnt, 0);
        check("rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
        check("rst_do", {r1_do, r0_do}, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_di", ram_di, 0);
        check("rst_busy", clr_busy, 0);
        check("rst_cr_busy", c_clr_busy, 0);
        check("rst_cr_ram_en", c_ram_en, 0);
        r0_req = 1'b0; r1_req = 1'b0;
        step();
        rst_n = 1'b1;

        // Contention: round-robin alternates starting with R0, fixed priority always R0
        r0_req = 1'b1; r1_req = 1'b1; r0_addr = 12'h010; r1_addr = 12'h020;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_r0_gnt", r0_gnt, (k % 2) == 0);
            check("rr_r1_gnt", r1_gnt, (k % 2) == 1);
            check("rr_ram_addr", ram_addr, (k % 2) == 0 ? 12'h010 : 12'h020);
            check("rr_r0_rvalid", r0_rvalid, (k > 0) && (((k - 1) % 2) == 0));
            check("rr_r1_rvalid", r1_rvalid, (k > 0) && (((k - 1) % 2) == 1));
            if (k < 3) begin
                if (f_r0_gnt) f0++;
                if (f_r1_gnt) f1++;
            end
            step();
        end
        r0_req = 1'b0; r1_req = 1'b0;
        @(negedge clk);
        check("rr_last_r1_rvalid", r1_rvalid, 1);
        check("rr_last_r0_rvalid", r0_rvalid, 0);
        check("idle_ram_en", ram_en, 0);
        check("idle_ram_we", ram_we, 0);
        check("fp_r0_gnt_cnt", f0, 3);
        check("fp_r1_gnt_cnt", f1, 0);

        // R0 writes 0xA to 0x123, then reads it back
        step();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 12'h123; r0_di = 4'hA;
        @(negedge clk);
        check("wr_gnt", r0_gnt, 1);
        check("wr_ram_en", ram_en, 1);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 12'h123);
        check("wr_ram_di", ram_di, 4'hA);
        step();
        r0_we = 1'b0;
        @(negedge clk);
        check("rd_gnt0", r0_gnt, 1);
        check("rd_ram_we", ram_we, 0);
        check("wr_no_rvalid", r0_rvalid, 0);
        step();
        r0_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid0", r0_rvalid, 1);
        check("rd_do0", r0_do, 4'hA);
        check("rd_r1_quiet", r1_rvalid, 0);
        step();
        @(negedge clk);
        check("do_hold_vld", r0_rvalid, 0);
        check("do_hold", r0_do, 4'hA);

        // Read granted right before CLR_START still returns data
        step();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h123;
        @(negedge clk);
        check("pre_clr_gnt", r0_gnt, 1);
        step();
        clr_start = 1'b1; r1_req = 1'b1;
        @(negedge clk);
        check("clr_start_r0_gnt", r0_gnt, 0);
        check("clr_start_r1_gnt", r1_gnt, 0);
        check("clr_start_ram_en", ram_en, 0);
        check("clr_start_busy", clr_busy, 0);
        check("owed_rvalid", r0_rvalid, 1);
        check("owed_do", r0_do, 4'hA);
        step();
        clr_start = 1'b0;

        // Sweep: 4096 busy cycles, ascending addresses, no grants, restart attempt at cycle 100 ignored
        busy_n = 0; gnt_n = 0; addr_ok = 0;
        for (int c = 0; c < 4100; c++) begin
            @(negedge clk);
            if (clr_busy) busy_n++;
            if (c < 4096) begin
                if (r0_gnt || r1_gnt) gnt_n++;
                if (ram_en && ram_we && ram_addr == 12'(c) && ram_di == 4'h5) addr_ok++;
            end
            if (c == 4096) begin
                check("post_clr_r1_gnt", r1_gnt, 1);
                check("post_clr_r0_gnt", r0_gnt, 0);
            end
            step();
            clr_start = (c == 99);
        end
        r0_req = 1'b0; r1_req = 1'b0;
        check("clr_busy_cycles", busy_n, 4096);
        check("clr_gnt_cycles", gnt_n, 0);
        check("clr_addr_ok", addr_ok, 4096);

        do_read(12'h000, 4'h5);
        do_read(12'h7FF, 4'h5);
        do_read(12'hFFF, 4'h5);

        // Clear-on-reset instance: abort mid-sweep, then a full sweep from address 0
        step();
        r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b0; r1_we = 1'b0;
        rst_n_c = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("cr_start_busy", c_clr_busy, 1);
                check("cr_start_addr", c_ram_addr, 0);
            end
            step();
        end
        @(negedge clk);
        check("cr_addr_2000", c_ram_addr, 12'd2000);
        #1 rst_n_c = 1'b0;
        #1;
        check("cr_abort_busy", c_clr_busy, 0);
        check("cr_abort_ram_en", c_ram_en, 0);
        check("cr_abort_ram_we", c_ram_we, 0);
        check("cr_abort_ram_addr", c_ram_addr, 0);
        check("cr_abort_ram_di", c_ram_di, 0);
        check("cr_abort_gnt", {c_r1_gnt, c_r0_gnt}, 0);
        check("cr_abort_rvalid", {c_r1_rvalid, c_r0_rvalid}, 0);
        step();
        rst_n_c = 1'b1;
        busy_n = 0; gnt_n = 0; addr_ok = 0;
        for (int c = 0; c < 4100; c++) begin
            @(negedge clk);
            if (c_clr_busy) busy_n++;
            if (c < 4096) begin
                if (c_r0_gnt || c_r1_gnt) gnt_n++;
                if (c_ram_en && c_ram_we && c_ram_addr == 12'(c) && c_ram_di == 4'h0) addr_ok++;
            end
            if (c == 4096) check("cr_first_gnt_r0", c_r0_gnt, 1);
            step();
        end
        r0_req = 1'b0; r1_req = 1'b0;
        check("cr_busy_cycles", busy_n, 4096);
        check("cr_gnt_cycles", gnt_n, 0);
        check("cr_addr_ok", addr_ok, 4096);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ramb16_s4_arb.md
RAMB16_S4_ARB -- requirements
Module: ramb16_s4_arb

Interface
REQ-001 SHALL have parameter RR_EN, default 1, where 1 is round-robin and 0 is fixed priority with R0 winning.
REQ-002 SHALL have parameter CLR_VAL, default 4'h0, the nibble written to every address during a clear sweep.
REQ-003 SHALL have parameter CLR_ON_RST, default 0, where 1 starts a clear sweep automatically on reset release.
REQ-004 SHALL have the port list below; there is one clock, and reset is asynchronous and active-low.
- CLK  in  1  clock; all logic on posedge
- RST_N  in  1  asynchronous active-low reset
- R0_REQ, R1_REQ  in  1  access request, held until granted
- R0_WE, R1_WE  in  1  1 = write, 0 = read
- R0_ADDR, R1_ADDR  in  12  nibble address
- R0_DI, R1_DI  in  4  write data
- R0_GNT, R1_GNT  out  1  combinational grant; access is taken this cycle
- R0_RVALID, R1_RVALID  out  1  read data valid
- R0_DO, R1_DO  out  4  read data
- CLR_START  in  1  single-cycle clear request
- CLR_BUSY  out  1  clear sweep in progress
- RAM_EN, RAM_WE  out  1  drive the enable and write-enable of one 4Kx4 RAM port
- RAM_ADDR  out  12  RAM address
- RAM_DI  out  4  RAM write data
- RAM_DO  in  4  RAM registered read data, valid one cycle after an enabled read

Function
REQ-005 SHALL implement two states, SERVE and CLEAR.
REQ-006 SERVE SHALL grant at most one requester per cycle; GNT SHALL depend only on REQ, state and the priority pointer.
REQ-007 With RR_EN=1 and both requesting, SHALL grant the requester not granted most recently; the pointer updates only on a grant.
REQ-008 With RR_EN=0, R0 SHALL always win when both request.
REQ-009 In a grant cycle, RAM_EN SHALL be 1 and RAM_WE/RAM_ADDR/RAM_DI SHALL equal the winner's WE/ADDR/DI.
REQ-010 In a non-grant cycle in SERVE, RAM_EN=0 and RAM_WE=0.
REQ-011 Read latency: Rn_RVALID SHALL pulse exactly 1 cycle after a granted read, with Rn_DO=RAM_DO in that cycle.
REQ-012 Rn_DO SHALL hold its value when RVALID=0; granted writes SHALL produce no RVALID.
REQ-013 Back-to-back grants SHALL be sustainable at 1 access per cycle with no bubble.
REQ-014 CLR_START in SERVE SHALL suppress all grants that cycle and enter CLEAR next cycle; the clear address counter starts at 0.
REQ-015 CLEAR SHALL write CLR_VAL to addresses 0..4095 in ascending order, one per cycle (RAM_EN=1, RAM_WE=1), 4096 cycles total, with no grants.
REQ-016 On the cycle writing address 4095, the counter SHALL wrap to 0 and the next state SHALL be SERVE; CLR_BUSY SHALL be 1 exactly during CLEAR cycles.
REQ-017 CLR_START during CLEAR SHALL be ignored; the sweep does not restart.
REQ-018 An RVALID owed from a read granted in the cycle before CLR_START was sampled SHALL still be delivered.

Reset
REQ-019 RST_N low SHALL asynchronously force: state SERVE (or CLEAR if CLR_ON_RST=1), clear counter 0, all GNT 0, all RVALID 0, all DO 4'h0, RAM_EN 0, RAM_WE 0, RAM_ADDR 0, RAM_DI 0.
REQ-020 After reset the round-robin pointer SHALL point at R1, so R0 wins the first contention.
REQ-021 Reset asserted mid-sweep SHALL abort the sweep; there is no resume.

Structure
REQ-022 A shared package ramb16_ctl_pkg SHALL hold the constants ADDR_W=12, DATA_W=4 and DEPTH=4096, plus the state encoding SERVE/CLEAR.
REQ-023 The 2-way round-robin arbiter SHALL be one sub-module, ramb16_rr_arb2, with req[1:0], gnt[1:0], an advance input and an RR_EN parameter.

Verification
REQ-024 Bench SHALL cover: R0 writes 0xA to addr 0x123, then R0 reads 0x123 -> R0_RVALID 1 cycle after the read grant with R0_DO=0xA.
REQ-025 Bench SHALL cover: RR_EN=1, both requesting reads for 4 cycles -> grants R0,R1,R0,R1; each RVALID on its own port only.
REQ-026 Bench SHALL cover: RR_EN=0, both requesting for 3 cycles -> R0_GNT 3 times, R1_GNT 0.
REQ-027 Bench SHALL cover: CLR_VAL=0x5, CLR_START pulse -> CLR_BUSY high for exactly 4096 cycles, no GNT; reads of 0x000, 0x7FF and 0xFFF afterwards return 0x5.
REQ-028 Bench SHALL cover: CLR_START pulsed again at sweep cycle 100 -> sweep still ends at cycle 4096.
REQ-029 Bench SHALL cover: RST_N low at sweep cycle 2000 -> all outputs 0 immediately; with CLR_ON_RST=1, a full 4096-cycle sweep restarts at address 0.
